// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: serial issue stage for the external 32-bit ALU.
// Accepts one instruction over a valid/ready handshake, reads operands from an
// 8x32 register file, drives the ALU and commits the result and flags back.
module alu_issue_ctrl (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [31:0] Instr,
  output logic [31:0] ALUA,
  output logic [31:0] ALUB,
  output logic [3:0]  ALUControl,
  output logic        ALUFlagIn,
  input  logic [31:0] ALUResult,
  input  logic [3:0]  ALUFlags,
  output logic [3:0]  FlagReg,
  output logic        WbValid,
  output logic [2:0]  WbAddr,
  output logic [31:0] WbData,
  output logic        IllegalOp,
  output logic        Busy,
  input  logic [2:0]  RdAddr,
  output logic [31:0] RdData
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e      state_q, state_d;
  logic        ready_q;
  logic [2:0]  rd_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_ctrl_q;
  logic        alu_fin_q;
  logic [3:0]  flag_q;
  logic        wb_valid_q, illegal_q;
  logic [2:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic [31:0] rf_q [8];

  // Instruction field decode
  logic [3:0]  f_op;
  logic        f_use_imm;
  logic [2:0]  f_rd, f_rs1, f_rs2;
  logic [1:0]  f_fsel;
  logic [15:0] f_imm;
  logic        accept, legal, fin_sel;

  assign f_op      = Instr[31:28];
  assign f_use_imm = Instr[27];
  assign f_rd      = Instr[26:24];
  assign f_rs1     = Instr[23:21];
  assign f_rs2     = Instr[20:18];
  assign f_fsel    = Instr[17:16];
  assign f_imm     = Instr[15:0];

  assign legal  = (f_op <= 4'd9);
  assign accept = InstrValid && InstrReady;

  // Carry-in source; 2'b11 is reserved and behaves like 2'b00
  always_comb begin
    fin_sel = 1'b0;
    unique case (f_fsel)
      2'b01:   fin_sel = 1'b1;
      2'b10:   fin_sel = flag_q[2];
      default: fin_sel = 1'b0;
    endcase
  end

  // Next-state logic: illegal ops are consumed in IDLE without leaving it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && legal) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; ready_q keeps InstrReady low until the first edge out of reset
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
    end
  end

  // Operand and control registers, loaded only on a legal accept
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      alu_fin_q  <= 1'b0;
      rd_q       <= '0;
    end else if (accept && legal) begin
      alu_a_q    <= rf_q[f_rs1];
      alu_b_q    <= f_use_imm ? {16'h0, f_imm} : rf_q[f_rs2];
      alu_ctrl_q <= f_op;
      alu_fin_q  <= fin_sel;
      rd_q       <= f_rd;
    end
  end

  // Illegal-op pulse, one cycle after the accepting edge
  always_ff @(posedge Clk) begin
    if (!Rst_n) illegal_q <= 1'b0;
    else        illegal_q <= accept && !legal;
  end

  // Writeback on the edge leaving WB; reset discards a pending write
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      flag_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      if (state_q == StWb) begin
        rf_q[rd_q] <= ALUResult;
        flag_q     <= ALUFlags;
        wb_valid_q <= 1'b1;
        wb_addr_q  <= rd_q;
        wb_data_q  <= ALUResult;
      end
    end
  end

  assign InstrReady = (state_q == StIdle) && ready_q;
  assign Busy       = (state_q != StIdle);
  assign ALUA       = alu_a_q;
  assign ALUB       = alu_b_q;
  assign ALUControl = alu_ctrl_q;
  assign ALUFlagIn  = alu_fin_q;
  assign FlagReg    = flag_q;
  assign WbValid    = wb_valid_q;
  assign WbAddr     = wb_addr_q;
  assign WbData     = wb_data_q;
  assign IllegalOp  = illegal_q;
  assign RdData     = rf_q[RdAddr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the falling edge, reference
// register file, and a writeback scoreboard filled at each accept.
module tb_alu_issue_ctrl;

  logic        Clk, Rst_n, InstrValid, InstrReady;
  logic [31:0] Instr, ALUA, ALUB, ALUResult, WbData, RdData;
  logic [3:0]  ALUControl, ALUFlags, FlagReg;
  logic        ALUFlagIn, WbValid, IllegalOp, Busy;
  logic [2:0]  WbAddr, RdAddr;

  alu_issue_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .ALUA(ALUA), .ALUB(ALUB), .ALUControl(ALUControl),
    .ALUFlagIn(ALUFlagIn), .ALUResult(ALUResult), .ALUFlags(ALUFlags),
    .FlagReg(FlagReg), .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
    .IllegalOp(IllegalOp), .Busy(Busy), .RdAddr(RdAddr), .RdData(RdData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  flags;
  } wb_t;

  wb_t         sb[$];
  logic [31:0] ref_r [8];
  logic [3:0]  ref_flags;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  // Returns {V,C,Z,N,result}
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci);
    logic [32:0] t;
    logic [31:0] r;
    logic        c, v;
    t = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        t = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        r = t[31:0]; c = t[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        t = {1'b0, a} - {1'b0, b} - {32'b0, ci};
        r = t[31:0]; c = t[32]; v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a + 32'd1;
      4'd3: r = a - 32'd1;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = ~a;
      4'd7: r = a ^ b;
      4'd8: begin r = {ci, a[31:1]}; c = a[0]; end
      4'd9: begin r = {a[30:0], ci}; c = a[31]; end
      default: r = '0;
    endcase
    return {v, c, (r == 32'd0), r[31], r};
  endfunction

  // Behavioural ALU: registers its result on the falling edge
  always @(negedge Clk) {ALUFlags, ALUResult} <= alu_fn(ALUControl, ALUA, ALUB, ALUFlagIn);

  function automatic logic [31:0] mk(input logic [3:0] op, input logic ui, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [1:0] fsel, input logic [15:0] imm);
    return {op, ui, rd, rs1, rs2, fsel, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    ref_flags = '0;
    sb.delete();
  endtask

  // Model the instruction at its accept edge and queue the expected writeback
  task automatic push_exp(input logic [31:0] ins);
    logic [31:0] a, b;
    logic        ci;
    logic [35:0] res;
    wb_t         e;
    if (ins[31:28] > 4'd9) return;
    a  = ref_r[ins[23:21]];
    b  = ins[27] ? {16'h0, ins[15:0]} : ref_r[ins[20:18]];
    ci = (ins[17:16] == 2'b01) ? 1'b1 : (ins[17:16] == 2'b10) ? ref_flags[2] : 1'b0;
    res = alu_fn(ins[31:28], a, b, ci);
    e.addr = ins[26:24]; e.data = res[31:0]; e.flags = res[35:32];
    sb.push_back(e);
    ref_r[e.addr] = e.data;
    ref_flags = e.flags;
  endtask

  task automatic pop_cmp(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_addr"}, 32'(WbAddr), 32'(e.addr));
    check({tag, "_data"}, WbData, e.data);
    check({tag, "_flags"}, 32'(FlagReg), 32'(e.flags));
    RdAddr = e.addr;
    #1;
    check({tag, "_rf"}, RdData, e.data);
  endtask

  // Offer an instruction and wait (bounded) for its accept edge
  task automatic issue(input logic [31:0] ins);
    int n;
    InstrValid = 1'b1;
    Instr = ins;
    n = 0;
    while (!InstrReady && n < 10) begin tick(); n++; end
    if (!InstrReady) check("issue_timeout", 32'd0, 32'd1);
    tick();
    push_exp(ins);
    InstrValid = 1'b0;
  endtask

  // Called just after the accept edge: WbValid must rise two edges later
  task automatic wait_wb(input string tag);
    int lat;
    lat = 0;
    while (!WbValid && lat < 8) begin tick(); lat++; end
    check({tag, "_lat"}, 32'(lat), 32'd2);
    if (WbValid) pop_cmp(tag);
    tick();
    check({tag, "_pulse"}, 32'(WbValid), 32'd0);
  endtask

  initial begin
    Rst_n = 1'b0; InstrValid = 1'b0; Instr = '0; RdAddr = '0;
    ref_reset();

    // Reset
    tick(); tick();
    check("rst_ready_low", 32'(InstrReady), 32'd0);
    Rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      RdAddr = 3'(i);
      #1;
      check($sformatf("rst_r%0d", i), RdData, 32'd0);
    end
    check("rst_flags", 32'(FlagReg), 32'd0);
    check("rst_ready", 32'(InstrReady), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_wbvalid", 32'(WbValid), 32'd0);

    // ADD immediate: R1 = R0 + 5
    issue(mk(4'd0, 1'b1, 3'd1, 3'd0, 3'd0, 2'b00, 16'd5));
    check("add_ctrl", 32'(ALUControl), 32'd0);
    check("add_b", ALUB, 32'd5);
    check("add_busy", 32'(Busy), 32'd1);
    check("add_notready", 32'(InstrReady), 32'd0);
    wait_wb("add");
    check("add_z", 32'(FlagReg[1]), 32'd0);

    // SUB to zero: R2 = R1 - 5
    issue(mk(4'd1, 1'b1, 3'd2, 3'd1, 3'd0, 2'b00, 16'd5));
    wait_wb("sub");
    check("sub_z", 32'(FlagReg[1]), 32'd1);

    // Illegal opcode: one-cycle pulse, nothing committed, still ready
    issue(mk(4'hC, 1'b1, 3'd3, 3'd1, 3'd0, 2'b00, 16'h1234));
    check("ill_pulse", 32'(IllegalOp), 32'd1);
    check("ill_ready", 32'(InstrReady), 32'd1);
    check("ill_busy", 32'(Busy), 32'd0);
    tick();
    check("ill_pulse_end", 32'(IllegalOp), 32'd0);
    check("ill_nowb", 32'(WbValid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      RdAddr = 3'(i);
      #1;
      check($sformatf("ill_r%0d", i), RdData, ref_r[i]);
    end

    // Back-to-back with InstrValid held: A = R1+0x10+1 -> R6, B = R6<<1 -> R7
    InstrValid = 1'b1;
    Instr = mk(4'd0, 1'b1, 3'd6, 3'd1, 3'd0, 2'b01, 16'h0010);
    check("b2b_ready_t0", 32'(InstrReady), 32'd1);
    tick();
    push_exp(Instr);
    Instr = mk(4'd9, 1'b0, 3'd7, 3'd6, 3'd0, 2'b00, 16'hFFFF);
    check("b2b_fin", 32'(ALUFlagIn), 32'd1);
    check("b2b_notready_t0", 32'(InstrReady), 32'd0);
    tick();
    check("b2b_notready_t1", 32'(InstrReady), 32'd0);
    check("b2b_a_held", ALUB, 32'h10);
    tick();
    check("b2b_ready_t2", 32'(InstrReady), 32'd1);
    check("b2b_wb_a", 32'(WbValid), 32'd1);
    pop_cmp("b2b_a");
    tick();
    push_exp(Instr);
    InstrValid = 1'b0;
    check("b2b_accept_t3", 32'(InstrReady), 32'd0);
    check("b2b_ctrl_b", 32'(ALUControl), 32'd9);
    check("b2b_a_b", ALUA, 32'd22);
    wait_wb("b2b_b");

    // Reset while in WB: pending write to R3 must be dropped
    issue(mk(4'd0, 1'b1, 3'd3, 3'd0, 3'd0, 2'b00, 16'd7));
    tick();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    ref_reset();
    check("rwb_wbvalid", 32'(WbValid), 32'd0);
    check("rwb_busy", 32'(Busy), 32'd0);
    check("rwb_ready_low", 32'(InstrReady), 32'd0);
    check("rwb_alua", ALUA, 32'd0);
    check("rwb_flags", 32'(FlagReg), 32'd0);
    tick();
    check("rwb_ready", 32'(InstrReady), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rwb_nowb%0d", i), 32'(WbValid), 32'd0);
      tick();
    end
    RdAddr = 3'd3;
    #1;
    check("rwb_r3", RdData, 32'd0);
    RdAddr = 3'd1;
    #1;
    check("rwb_r1", RdData, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
